// File: rtl/report_checker_multi.sv
// report_checker_multi: streams levels of a report through MAX_LEVELS+1
// checker lanes. Lane 0 sees every level. Lane k drops the level at report
// index k-1. At the end of the report it gives a safe/damped verdict and
// updates the saturating report counters.
//
// state  | meaning
// FIRST  | no effective level seen yet in this report
// SECOND | one level stored, direction not yet known
// ASC    | strictly ascending so far, every step within delta bounds
// DESC   | strictly descending so far, every step within delta bounds
// UNSAFE | a step broke the rules; held until the report ends
module report_checker_multi #(
  parameter int WIDTH      = 8,
  parameter int MAX_LEVELS = 8,
  parameter int MIN_DELTA  = 1,
  parameter int MAX_DELTA  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_val,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic                 out_safe,
  output logic                 out_damped,
  output logic                 out_overflow,
  output logic [CNT_WIDTH-1:0] safe_count,
  output logic [CNT_WIDTH-1:0] damped_count
);

  typedef enum logic [2:0] {FIRST, SECOND, ASC, DESC, UNSAFE} lane_state_t;

  // The index saturates at MAX_LEVELS. That value means "beyond the skip lanes".
  localparam int IDX_W = $clog2(MAX_LEVELS + 1);
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(MAX_LEVELS);
  localparam logic signed [WIDTH:0] MIN_D = MIN_DELTA[WIDTH:0];
  localparam logic signed [WIDTH:0] MAX_D = MAX_DELTA[WIDTH:0];

  logic [IDX_W-1:0]  idx;
  logic              close;
  logic              overflow_c;
  logic              damped_c;
  logic [MAX_LEVELS:0] lane_safe;
  logic [MAX_LEVELS:0] lane_valid;

  assign close      = in_valid && in_last;
  assign overflow_c = (idx == IDX_SAT);

  // Report index: counts accepted levels and clears at the end of a report.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (in_valid) begin
      if (in_last)             idx <= '0;
      else if (idx != IDX_SAT) idx <= idx + 1'b1;
    end
  end

  for (genvar k = 0; k <= MAX_LEVELS; k++) begin : g_lane
    lane_state_t        state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               skip;
    logic signed [WIDTH:0] up, dn;
    logic               up_ok, dn_ok;

    if (k == 0) begin : g_noskip
      assign skip          = 1'b0;
      assign lane_valid[k] = 1'b1;
    end else begin : g_skip
      assign skip          = (idx == IDX_W'(k - 1));
      assign lane_valid[k] = (IDX_W'(k - 1) <= idx);
    end

    // Zero-extended subtraction: a full-range jump never wraps into range.
    assign up    = $signed({1'b0, in_val}) - $signed({1'b0, prev_q});
    assign dn    = $signed({1'b0, prev_q}) - $signed({1'b0, in_val});
    assign up_ok = (up >= MIN_D) && (up <= MAX_D);
    assign dn_ok = (dn >= MIN_D) && (dn <= MAX_D);

    // Next lane state for the level on the input. A skipped level leaves the lane untouched.
    always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      if (!skip) begin
        case (state_q)
          FIRST: begin
            state_d = SECOND;
            prev_d  = in_val;
          end
          SECOND: begin
            prev_d = in_val;
            if (up_ok)      state_d = ASC;
            else if (dn_ok) state_d = DESC;
            else            state_d = UNSAFE;
          end
          ASC: begin
            prev_d = in_val;
            if (!up_ok) state_d = UNSAFE;
          end
          DESC: begin
            prev_d = in_val;
            if (!dn_ok) state_d = UNSAFE;
          end
          default: state_d = UNSAFE;
        endcase
      end
    end

    // Lane state register: advances on each level and rearms at end of report.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= FIRST;
        prev_q  <= '0;
      end else if (in_valid) begin
        state_q <= in_last ? FIRST : state_d;
        prev_q  <= prev_d;
      end
    end

    assign lane_safe[k] = (state_d != UNSAFE);
  end

  assign damped_c = overflow_c ? lane_safe[0] : |(lane_safe & lane_valid);

  // Verdict register and saturating counters, all updated on the closing beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_safe     <= 1'b0;
      out_damped   <= 1'b0;
      out_overflow <= 1'b0;
      safe_count   <= '0;
      damped_count <= '0;
    end else begin
      out_valid    <= close;
      out_safe     <= close && lane_safe[0];
      out_damped   <= close && damped_c;
      out_overflow <= close && overflow_c;
      if (close && lane_safe[0] && (safe_count != '1))
        safe_count <= safe_count + 1'b1;
      if (close && damped_c && (damped_count != '1))
        damped_count <= damped_count + 1'b1;
    end
  end

endmodule

// File: doc/report_checker_multi.md
REPORT_CHECKER_MULTI -- requirements
Module: report_checker_multi

Interface
REQ-001 Parameter WIDTH, default 8, level value width (unsigned).
REQ-002 Parameter MAX_LEVELS, default 8, maximum levels per report supported by skip lanes.
REQ-003 Parameter MIN_DELTA, default 1, minimum allowed |step| between adjacent levels.
REQ-004 Parameter MAX_DELTA, default 3, maximum allowed |step| between adjacent levels.
REQ-005 Parameter CNT_WIDTH, default 16, width of the report counters.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  a level is presented this cycle.
REQ-009 in_val  input  WIDTH  level value.
REQ-010 in_last  input  1  qualifies in_valid; marks the final level of a report.
REQ-011 out_valid  output  1  one-cycle pulse: verdict for the completed report.
REQ-012 out_safe  output  1  report safe with no level removed.
REQ-013 out_damped  output  1  report safe with at most one level removed.
REQ-014 out_overflow  output  1  report exceeded MAX_LEVELS levels.
REQ-015 safe_count  output  CNT_WIDTH  total reports with out_safe=1.
REQ-016 damped_count  output  CNT_WIDTH  total reports with out_damped=1.

Function
REQ-017 Block SHALL contain MAX_LEVELS+1 identical lanes: lane 0 skips nothing; lane k (1..MAX_LEVELS) ignores the level at report index k-1.
REQ-018 Report index SHALL start at 0, increment on each in_valid, return to 0 after in_valid&&in_last; cycles with in_valid=0 SHALL change nothing.
REQ-019 Each lane SHALL be an FSM: FIRST, SECOND, ASC, DESC, UNSAFE; all lanes return to FIRST after in_valid&&in_last.
REQ-020 FIRST: store level, go SECOND.
REQ-021 SECOND: d=level-prev; MIN_DELTA<=d<=MAX_DELTA -> ASC; MIN_DELTA<=-d<=MAX_DELTA -> DESC; else UNSAFE; store level.
REQ-022 ASC/DESC: step in same direction within [MIN_DELTA,MAX_DELTA] -> stay, store level; else UNSAFE.
REQ-023 UNSAFE SHALL be absorbing until end of report.
REQ-024 Differences SHALL be computed in WIDTH+1 bits; no wrap-around (0 then 255 at WIDTH=8 is |step|=255, unsafe).
REQ-025 Lane verdict SHALL be safe iff lane not UNSAFE after the last level is applied; reports with 0 or 1 effective levels SHALL be safe.
REQ-026 A skipped level that is also in_last SHALL close the lane using its prior state.
REQ-027 Lanes whose skip index >= report length SHALL be ignored for the verdict.
REQ-028 out_safe = lane 0 verdict; out_damped = OR of all valid lane verdicts (out_safe implies out_damped).
REQ-029 A report with more than MAX_LEVELS levels SHALL set out_overflow=1 and force out_damped=out_safe (lane 0 still evaluates all levels).
REQ-030 out_valid, out_safe, out_damped, out_overflow SHALL be registered, asserted exactly one cycle after the in_valid&&in_last cycle; verdict bits SHALL be 0 whenever out_valid=0.
REQ-031 Back-to-back reports SHALL be supported: a new report's first level may arrive the cycle after in_last with no bubble.
REQ-032 safe_count/damped_count SHALL increment in the cycle out_valid rises for qualifying reports and SHALL saturate at all-ones.

Reset
REQ-033 rst=1 SHALL set all lanes to FIRST, index to 0, out_valid/out_safe/out_damped/out_overflow to 0, both counters to 0.
REQ-034 rst mid-report SHALL discard the partial report; no out_valid for it; next in_valid is index 0.
REQ-035 rst SHALL take priority over in_valid in the same cycle.

Verification
REQ-036 Stream 7 6 4 2 1 (last on 1) -> out_valid one cycle later, out_safe=1, out_damped=1.
REQ-037 Stream 1 2 7 8 9 -> out_safe=0, out_damped=0; then 1 3 2 4 5 -> out_safe=0, out_damped=1.
REQ-038 Six back-to-back reports 7 6 4 2 1 / 1 2 7 8 9 / 9 7 6 2 1 / 1 3 2 4 5 / 8 6 4 4 1 / 1 3 6 7 9, gaps of in_valid=0 inserted randomly -> safe_count=2, damped_count=4.
REQ-039 Single-level report 5 (in_last on first beat) -> out_safe=1, out_damped=1; report 0 255 -> out_safe=0, out_damped=1.
REQ-040 MAX_LEVELS=8, ten-level report 1..10 -> out_overflow=1, out_safe=1, out_damped=1; next report 5 5 5 -> out_overflow=0, out_damped=0.
REQ-041 Assert rst after levels 1 2 3 of a report, then send 9 8 -> only one out_valid, out_safe=1; counters reflect only post-reset reports.
